// File: rtl/in_channel.sv
// Input-channel FIFO feeding the test-program executor.
// Producer pushes via valid/ready; executor pops via readEnable.
module in_channel #(
  parameter int MemoryElementWidth = 12,
  parameter int NIn                = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          loadValid,
  input  logic [MemoryElementWidth-1:0] loadData,
  output logic                          loadReady,
  input  logic                          readEnable,
  output logic [MemoryElementWidth-1:0] readData,
  output logic                          readValid,
  output logic [MemoryElementWidth-1:0] size,
  output logic                          empty,
  output logic                          full,
  output logic                          underflow
);

  localparam int PW = (NIn > 1) ? $clog2(NIn) : 1;
  localparam int CW = $clog2(NIn + 1);
  localparam int W  = MemoryElementWidth;

  localparam logic [PW-1:0] PtrLast = PW'(NIn - 1);
  localparam logic [CW-1:0] CntFull = CW'(NIn);

  logic [W-1:0]  mem_q [NIn];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          uflow_q, uflow_d;
  logic          push, pop;

  // Status decoded purely from the registered count.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CntFull);
    loadReady = !full;
    size      = W'(count_q);
    readData  = rdata_q;
    readValid = rvalid_q;
    underflow = uflow_q;
  end

  // Handshake decode, pointer wrap and next-state computation.
  always_comb begin
    push     = loadValid && !full && !clear;
    pop      = readEnable && !empty && !clear;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    uflow_d  = uflow_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      rdata_d  = '0;
      uflow_d  = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rdata_d  = mem_q[rd_ptr_q];
        rvalid_d = 1'b1;
        rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PW'(1);
      end
      if (readEnable && empty) begin
        uflow_d = 1'b1;
      end
      unique case (1'b1)
        push && !pop: count_d = count_q + CW'(1);
        pop && !push: count_d = count_q - CW'(1);
        default:      count_d = count_q;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      uflow_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      uflow_q  <= uflow_d;
    end
  end

  // Word storage; contents are never reset, only overwritten.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= loadData;
    end
  end

endmodule

// File: tb/tb_in_channel.sv
// Bench for in_channel: directed vector table, reset/clear
// sequence, then random traffic against a queue model.
module tb_in_channel;

  localparam int W = 12;
  localparam int N = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         clear = 1'b0;
  logic         loadValid = 1'b0;
  logic [W-1:0] loadData = '0;
  logic         loadReady;
  logic         readEnable = 1'b0;
  logic [W-1:0] readData;
  logic         readValid;
  logic [W-1:0] size;
  logic         empty;
  logic         full;
  logic         underflow;

  int checks = 0;
  int errors = 0;

  in_channel #(.MemoryElementWidth(W), .NIn(N)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .loadValid(loadValid), .loadData(loadData),
    .loadReady(loadReady), .readEnable(readEnable),
    .readData(readData), .readValid(readValid),
    .size(size), .empty(empty), .full(full),
    .underflow(underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       lv;
    logic [W-1:0] ld;
    logic       re;
    logic       cl;
    int         rd;
    int         rv;
    int         sz;
    int         uf;
  } vec_t;

  vec_t tbl [28];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int rd, int rv, int sz, int uf);
    chk({tag, " readData"}, 32'(readData), rd);
    chk({tag, " readValid"}, 32'(readValid), rv);
    chk({tag, " size"}, 32'(size), sz);
    chk({tag, " empty"}, 32'(empty), (sz == 0) ? 1 : 0);
    chk({tag, " full"}, 32'(full), (sz == N) ? 1 : 0);
    chk({tag, " underflow"}, 32'(underflow), uf);
    chk({tag, " loadReady"}, 32'(loadReady), (sz == N) ? 0 : 1);
  endtask

  task automatic step(logic lv, logic [W-1:0] ld, logic re, logic cl);
    loadValid  = lv;
    loadData   = ld;
    readEnable = re;
    clear      = cl;
    @(posedge clock);
    #1;
    loadValid  = 1'b0;
    readEnable = 1'b0;
    clear      = 1'b0;
  endtask

  function automatic vec_t v(logic lv, int ld, logic re, logic cl,
                             int rd, int rv, int sz, int uf);
    vec_t t;
    t.lv = lv; t.ld = W'(ld); t.re = re; t.cl = cl;
    t.rd = rd; t.rv = rv; t.sz = sz; t.uf = uf;
    return t;
  endfunction

  // Random-phase reference model
  int unsigned mq[$];
  int m_rd, m_rv, m_uf;

  initial begin
    // fill / drain
    tbl[0]  = v(1, 33, 0, 0,  0, 0, 1, 0);
    tbl[1]  = v(1, 22, 0, 0,  0, 0, 2, 0);
    tbl[2]  = v(1, 11, 0, 0,  0, 0, 3, 0);
    tbl[3]  = v(0,  0, 1, 0, 33, 1, 2, 0);
    tbl[4]  = v(0,  0, 1, 0, 22, 1, 1, 0);
    tbl[5]  = v(0,  0, 1, 0, 11, 1, 0, 0);
    // wrap-around
    tbl[6]  = v(1,  1, 0, 0, 11, 0, 1, 0);
    tbl[7]  = v(1,  2, 0, 0, 11, 0, 2, 0);
    tbl[8]  = v(1,  3, 0, 0, 11, 0, 3, 0);
    tbl[9]  = v(0,  0, 1, 0,  1, 1, 2, 0);
    tbl[10] = v(1,  4, 0, 0,  1, 0, 3, 0);
    tbl[11] = v(0,  0, 1, 0,  2, 1, 2, 0);
    tbl[12] = v(0,  0, 1, 0,  3, 1, 1, 0);
    tbl[13] = v(0,  0, 1, 0,  4, 1, 0, 0);
    // simultaneous push/pop
    tbl[14] = v(1,  7, 0, 0,  4, 0, 1, 0);
    tbl[15] = v(1,  8, 1, 0,  7, 1, 1, 0);
    tbl[16] = v(0,  0, 1, 0,  8, 1, 0, 0);
    tbl[17] = v(1,  5, 1, 0,  8, 0, 1, 1);
    tbl[18] = v(0,  0, 1, 0,  5, 1, 0, 1);
    // full refusal
    tbl[19] = v(1, 10, 0, 0,  5, 0, 1, 1);
    tbl[20] = v(1, 20, 0, 0,  5, 0, 2, 1);
    tbl[21] = v(1, 30, 0, 0,  5, 0, 3, 1);
    tbl[22] = v(1,  9, 1, 0, 10, 1, 2, 1);
    tbl[23] = v(0,  0, 1, 0, 20, 1, 1, 1);
    tbl[24] = v(0,  0, 1, 0, 30, 1, 0, 1);
    tbl[25] = v(0,  0, 1, 0, 30, 0, 0, 1);
    // clear beats a push
    tbl[26] = v(1,  6, 0, 1,  0, 0, 0, 0);
    tbl[27] = v(0,  0, 0, 0,  0, 0, 0, 0);

    #1;
    chk_all("reset", 0, 0, 0, 0);
    #12;
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].lv, tbl[i].ld, tbl[i].re, tbl[i].cl);
      chk_all($sformatf("vec%0d", i),
              tbl[i].rd, tbl[i].rv, tbl[i].sz, tbl[i].uf);
    end

    // asynchronous reset mid-stream with size=2, underflow=1
    step(0, 0, 1, 0);
    step(1, 44, 0, 0);
    step(1, 55, 1, 0);
    step(1, 66, 0, 0);
    chk_all("pre-reset", 44, 0, 2, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async-reset", 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    step(1, 77, 0, 1);
    chk_all("clear-push", 0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk_all("after-clear-pop", 0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_all("clear-uf", 0, 0, 0, 0);

    // random traffic against the queue model
    mq.delete();
    m_rd = 0; m_rv = 0; m_uf = 0;
    for (int c = 0; c < 600; c++) begin
      logic lv, re, cl;
      logic [W-1:0] ld;
      lv = ($urandom_range(0, 99) < 60);
      re = ($urandom_range(0, 99) < 50);
      cl = ($urandom_range(0, 99) < 3);
      ld = W'($urandom);
      if (cl) begin
        mq.delete();
        m_rd = 0; m_rv = 0; m_uf = 0;
      end else begin
        bit was_full;
        was_full = (mq.size() == N);
        m_rv = 0;
        if (re && mq.size() == 0) m_uf = 1;
        if (re && mq.size() > 0) begin
          m_rd = int'(mq.pop_front());
          m_rv = 1;
        end
        if (lv && !was_full) mq.push_back(int'(ld));
      end
      step(lv, ld, re, cl);
      chk_all($sformatf("rand%0d", c), m_rd, m_rv, mq.size(), m_uf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
